tx_frame_sched: RTL and testbench

Transmit-side frame scheduler between the six `filter_sinc3` channel outputs and the byte-wide `uart_tx`. On each sample strobe it snapshots all channel words and sequences them into one framed byte stream: sync byte, sequence number, channel data MSB-first, and an 8-bit checksum. It drives `uart_tx` through a valid/ready handshake, applies backpressure correctly, and counts strobes dropped while a frame is still in flight.

---
 rtl/tx_frame_sched.sv | 148 ++++++++++++++
 tb/tb_tx_frame_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_sched.sv
// tx_frame_sched: snapshots NCH channel words on a sample strobe and streams them
// to a byte-wide UART as SYNC, SEQ, data bytes (MSB first per channel), CSUM.
module tx_frame_sched #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NCH       = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_stb,
    input  logic [NCH*WIDTH-1:0]   data_in,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   overrun,
    output logic [7:0]             overrun_cnt,
    output logic [7:0]             seq
);

    localparam int unsigned BPW   = WIDTH / 8;
    localparam int unsigned NB    = NCH * BPW;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned DW    = NCH * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_DATA,
        S_CSUM
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [7:0]         csum, csum_n;
    logic [7:0]         seq_n;
    logic [7:0]         tx_data_n;
    logic [DW-1:0]      snapshot;
    logic               capture_c;
    logic               xfer_c;
    logic               drop_c;
    logic [7:0]         byte_arr [NB];

    // Flatten the snapshot into frame byte order: channel ascending, MSB byte first.
    for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
        for (genvar gb = 0; gb < BPW; gb++) begin : g_byte
            assign byte_arr[gc*BPW + gb] = snapshot[WIDTH*gc + WIDTH-1-8*gb -: 8];
        end
    end

    assign xfer_c = tx_valid & tx_ready;
    assign drop_c = sample_stb & (state != S_IDLE);

    // Next-state and next-byte selection; the byte for the next state is loaded on the
    // same edge as the transition so there is never a gap cycle.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        csum_n    = csum;
        seq_n     = seq;
        tx_data_n = tx_data;
        capture_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample_stb) begin
                    state_n   = S_SYNC;
                    tx_data_n = SYNC_BYTE;
                    csum_n    = 8'h00;
                    capture_c = 1'b1;
                end
            end
            S_SYNC: begin
                if (xfer_c) begin
                    state_n   = S_SEQ;
                    tx_data_n = seq;
                end
            end
            S_SEQ: begin
                if (xfer_c) begin
                    state_n   = S_DATA;
                    idx_n     = '0;
                    csum_n    = csum + tx_data;
                    tx_data_n = byte_arr[0];
                end
            end
            S_DATA: begin
                if (xfer_c) begin
                    csum_n = csum + tx_data;
                    if (idx == IDX_W'(NB - 1)) begin
                        state_n   = S_CSUM;
                        tx_data_n = csum + tx_data;
                    end else begin
                        idx_n     = idx + IDX_W'(1);
                        tx_data_n = byte_arr[idx + IDX_W'(1)];
                    end
                end
            end
            S_CSUM: begin
                if (xfer_c) begin
                    state_n   = S_IDLE;
                    seq_n     = seq + 8'd1;
                    tx_data_n = 8'h00;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Frame state, handshake outputs and snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            csum     <= 8'h00;
            seq      <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            snapshot <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            csum     <= csum_n;
            seq      <= seq_n;
            tx_data  <= tx_data_n;
            tx_valid <= (state_n != S_IDLE);
            busy     <= (state_n != S_IDLE);
            if (capture_c) begin
                snapshot <= data_in;
            end
        end
    end

    // Dropped-strobe pulse and saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            overrun_cnt <= 8'h00;
        end else begin
            overrun <= drop_c;
            if (drop_c && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched: frame contents, backpressure, overrun, wrap, reset.
module tb_tx_frame_sched;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_stb;
    logic [95:0]   data_in;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          overrun;
    logic [7:0]    overrun_cnt;
    logic [7:0]    seq;

    int n_checks = 0;
    int n_err    = 0;
    int ov_seen  = 0;

    logic [95:0] base_data;
    logic [95:0] alt_data;
    logic [7:0]  exp_f [15];
    logic [7:0]  exp_seq;

    always #5 clk = ~clk;

    tx_frame_sched #(.WIDTH(16), .NCH(6), .SYNC_BYTE(8'hA5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_stb  (sample_stb),
        .data_in     (data_in),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .seq         (seq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference frame from channel words and sequence number.
    function automatic void build_frame(input logic [7:0] sq, input logic [95:0] d,
                                        output logic [7:0] f [15]);
        logic [7:0] s;
        f[0] = 8'hA5;
        f[1] = sq;
        s = sq;
        for (int ch = 0; ch < 6; ch++) begin
            f[2 + 2*ch]     = d[16*ch + 15 -: 8];
            f[2 + 2*ch + 1] = d[16*ch + 7 -: 8];
            s = s + f[2 + 2*ch] + f[2 + 2*ch + 1];
        end
        f[14] = s;
    endfunction

    task automatic send_strobe(input logic [95:0] d);
        data_in    = d;
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
    endtask

    // Drain one frame; toggle=1 alternates tx_ready starting low. drop_a/drop_b are
    // frame-cycle indices at which an extra strobe with alt data is driven (-1 = none).
    task automatic run_frame(input string tag, input logic [7:0] e [15], input bit toggle,
                             input int drop_a, input int drop_b, input logic [95:0] alt);
        int   got = 0;
        int   cyc = 0;
        bit   prev_nr = 1'b0;
        logic [7:0] held = 8'h00;
        while (got < 15 && cyc < 200) begin
            if (overrun) ov_seen++;
            if (!tx_valid) begin
                check($sformatf("%s valid@%0d", tag, got), 32'(tx_valid), 32'd1);
                break;
            end
            if (prev_nr)
                check($sformatf("%s hold@%0d", tag, got), 32'(tx_data), 32'(held));
            tx_ready = toggle ? cyc[0] : 1'b1;
            if (cyc == drop_a || cyc == drop_b) begin
                sample_stb = 1'b1;
                data_in    = alt;
            end else begin
                sample_stb = 1'b0;
            end
            if (tx_ready) begin
                check($sformatf("%s byte%0d", tag, got), 32'(tx_data), 32'(e[got]));
                got++;
                prev_nr = 1'b0;
            end else begin
                held    = tx_data;
                prev_nr = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        sample_stb = 1'b0;
        if (overrun) ov_seen++;
        if (got < 15)
            check($sformatf("%s timeout", tag), 32'(got), 32'd15);
        if (!toggle)
            check($sformatf("%s cycles", tag), 32'(cyc), 32'd15);
        check($sformatf("%s busy_end", tag), 32'(busy), 32'd0);
        check($sformatf("%s valid_end", tag), 32'(tx_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] f1 [15];
        logic [7:0] f2 [15];
        logic [95:0] d;
        f1 = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03,
               8'h04, 8'h04, 8'h05, 8'h05, 8'h06, 8'h06, 8'h2A};
        f2 = '{8'hA5, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03,
               8'h04, 8'h04, 8'h05, 8'h05, 8'h06, 8'h06, 8'h2B};
        base_data = {16'h0606, 16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h0101};
        alt_data  = {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

        // Reset with random inputs
        rst_n = 1'b0;
        sample_stb = 1'b0;
        tx_ready = 1'b0;
        data_in = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst valid", 32'(tx_valid), 32'd0);
            check("rst data", 32'(tx_data), 32'h00);
            check("rst busy", 32'(busy), 32'd0);
            check("rst ovr", 32'(overrun), 32'd0);
            check("rst ocnt", 32'(overrun_cnt), 32'd0);
            check("rst seq", 32'(seq), 32'd0);
            sample_stb = 1'($urandom_range(1));
            tx_ready   = 1'($urandom_range(1));
            data_in    = {$urandom, $urandom, $urandom};
        end
        @(negedge clk);
        sample_stb = 1'b0;
        tx_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame, ready held high
        send_strobe(base_data);
        run_frame("single", f1, 1'b0, -1, -1, '0);
        check("single seq", 32'(seq), 32'h01);

        // Backpressure, ready toggling
        send_strobe(base_data);
        run_frame("bp", f2, 1'b1, -1, -1, '0);
        check("bp seq", 32'(seq), 32'h02);

        // Overrun on cycle 5 and on the CSUM transfer cycle
        ov_seen = 0;
        tx_ready = 1'b1;
        build_frame(8'h02, base_data, exp_f);
        send_strobe(base_data);
        run_frame("ovr", exp_f, 1'b0, 5, 14, alt_data);
        check("ovr cnt", 32'(overrun_cnt), 32'd2);
        check("ovr pulses", 32'(ov_seen), 32'd2);
        check("ovr idle", 32'(busy), 32'd0);

        // Reset mid-frame during DATA byte 5
        send_strobe(base_data);
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("mid pre data", 32'(tx_data), 32'h03);
        rst_n = 1'b0;
        #1;
        check("mid valid", 32'(tx_valid), 32'd0);
        check("mid busy", 32'(busy), 32'd0);
        check("mid data", 32'(tx_data), 32'h00);
        check("mid seq", 32'(seq), 32'h00);
        check("mid ocnt", 32'(overrun_cnt), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_strobe(alt_data);
        build_frame(8'h00, alt_data, exp_f);
        run_frame("postrst", exp_f, 1'b0, -1, -1, '0);

        // Sequence wrap over 257 frames from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_seq = 8'h00;
        for (int k = 0; k < 257; k++) begin
            d = {$urandom, $urandom, $urandom};
            build_frame(exp_seq, d, exp_f);
            send_strobe(d);
            run_frame($sformatf("wrap%0d", k), exp_f, 1'b0, -1, -1, '0);
            exp_seq = exp_seq + 8'd1;
        end
        check("wrap seq", 32'(seq), 32'h01);

        // Saturation: hold a frame in SYNC and drop 300 strobes
        tx_ready = 1'b0;
        d = base_data;
        send_strobe(d);
        for (int i = 0; i < 300; i++) begin
            sample_stb = 1'b1;
            data_in = alt_data;
            @(negedge clk);
            sample_stb = 1'b0;
            @(negedge clk);
            if (i == 253) check("sat 254", 32'(overrun_cnt), 32'd254);
        end
        check("sat cnt", 32'(overrun_cnt), 32'hFF);
        build_frame(exp_seq, d, exp_f);
        run_frame("satflush", exp_f, 1'b0, -1, -1, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
